// File: rtl/controle_ula_multiciclo_pkg.sv
// controle_ula_multiciclo_pkg: opcodes, FSM encoding, ALU control values and instruction field layout
package controle_ula_multiciclo_pkg;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } estado_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_BEQ = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    localparam logic CTRL_SOMA = 1'b0;
    localparam logic CTRL_SUB  = 1'b1;

    localparam int INSTR_W  = 12;
    localparam int OP_MSB   = 11;
    localparam int OP_LSB   = 10;
    localparam int RX_MSB   = 9;
    localparam int RX_LSB   = 8;
    localparam int RY_MSB   = 7;
    localparam int RY_LSB   = 6;
    localparam int IMM_MSB  = 5;
    localparam int IMM_LSB  = 0;

    localparam int NUM_REGS = 4;
    localparam int REG_AW   = 2;

    function automatic logic usa_sub(input logic [1:0] op);
        return op == OP_SUB || op == OP_BEQ;
    endfunction

endpackage

// File: rtl/controle_ula_multiciclo_banco_registradores.sv
// banco_registradores: 4xDATA_W register file, two async reads, one sync write; CONTROLE_DEBUG_PORT_EN adds a debug read port
module banco_registradores
    import controle_ula_multiciclo_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [REG_AW-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [REG_AW-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [REG_AW-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
`ifdef CONTROLE_DEBUG_PORT_EN
    ,
    input  logic [REG_AW-1:0] dbg_sel_i,
    output logic [DATA_W-1:0] dbg_data_o
`endif
);

    logic [DATA_W-1:0] r_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_REGS; i++) r_q[i] <= '0;
        end else if (we_i) begin
            r_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = r_q[raddr_a_i];
    assign rdata_b_o = r_q[raddr_b_i];

`ifdef CONTROLE_DEBUG_PORT_EN
    assign dbg_data_o = r_q[dbg_sel_i];
`endif

endmodule

// File: rtl/controle_ula_multiciclo.sv
// controle_ula_multiciclo: 4-state FETCH/DECODE/EXEC/WB sequencer feeding the ALU; CONTROLE_DEBUG_PORT_EN adds dbg_sel/dbg_data/dbg_state
module controle_ula_multiciclo
    import controle_ula_multiciclo_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PC_W   = 8,
    parameter int IMM_W  = 6
) (
    input  logic               clock,
    input  logic               resetn,
    output logic [PC_W-1:0]    pc,
    output logic               instr_req,
    input  logic               instr_ack,
    input  logic [INSTR_W-1:0] instr,
    output logic               ctrl_ula,
    output logic [DATA_W-1:0]  ula_num2,
    output logic [DATA_W-1:0]  ula_num1,
    input  logic [DATA_W-1:0]  ula_resultado,
    input  logic               ula_zero
`ifdef CONTROLE_DEBUG_PORT_EN
    ,
    input  logic [REG_AW-1:0]  dbg_sel,
    output logic [DATA_W-1:0]  dbg_data,
    output logic [1:0]         dbg_state
`endif
);

    localparam logic [PC_W-1:0] PC_UM = PC_W'(1);

    estado_t            state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0]  a_q, a_d, b_q, b_d, aluout_q, aluout_d;
    logic               ctrl_q, ctrl_d, z_q, z_d;

    logic [1:0]         op;
    logic [REG_AW-1:0]  rx, ry;
    logic [IMM_W-1:0]   imm;
    logic [DATA_W-1:0]  imm_zext, rd_a, rd_b;
    logic [PC_W-1:0]    imm_sext, pc_inc;
    logic               we;

    assign op       = ir_q[OP_MSB:OP_LSB];
    assign rx       = ir_q[RX_MSB:RX_LSB];
    assign ry       = ir_q[RY_MSB:RY_LSB];
    assign imm      = ir_q[IMM_LSB +: IMM_W];
    assign imm_zext = {{(DATA_W-IMM_W){1'b0}}, imm};
    assign imm_sext = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm};
    assign pc_inc   = pc_q + PC_UM;
    assign we       = state_q == ST_WB && op != OP_BEQ;

    banco_registradores #(.DATA_W(DATA_W)) u_banco (
        .clk_i     (clock),
        .rst_n_i   (resetn),
        .we_i      (we),
        .waddr_i   (rx),
        .wdata_i   (aluout_q),
        .raddr_a_i (rx),
        .rdata_a_o (rd_a),
        .raddr_b_i (ry),
        .rdata_b_o (rd_b)
`ifdef CONTROLE_DEBUG_PORT_EN
        ,
        .dbg_sel_i (dbg_sel),
        .dbg_data_o(dbg_data)
`endif
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_FETCH;
            pc_q     <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            ctrl_q   <= CTRL_SOMA;
            aluout_q <= '0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            ctrl_q   <= ctrl_d;
            aluout_q <= aluout_d;
            z_q      <= z_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        ctrl_d   = ctrl_q;
        aluout_d = aluout_q;
        z_d      = z_q;
        unique case (state_q)
            ST_FETCH: begin
                ir_d    = instr_ack ? instr : ir_q;
                state_d = instr_ack ? ST_DECODE : ST_FETCH;
            end
            ST_DECODE: begin
                a_d     = op == OP_LDI ? imm_zext : rd_a;
                b_d     = op == OP_LDI ? '0 : rd_b;
                ctrl_d  = usa_sub(op) ? CTRL_SUB : CTRL_SOMA;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                aluout_d = ula_resultado;
                z_d      = ula_zero;
                state_d  = ST_WB;
            end
            ST_WB: begin
                pc_d    = (op == OP_BEQ && z_q) ? pc_inc + imm_sext : pc_inc;
                state_d = ST_FETCH;
            end
        endcase
    end

    // Gated by resetn so the request drops the instant reset asserts.
    assign instr_req = resetn && state_q == ST_FETCH;
    assign pc        = pc_q;
    assign ctrl_ula  = ctrl_q;
    assign ula_num2  = a_q;
    assign ula_num1  = b_q;

`ifdef CONTROLE_DEBUG_PORT_EN
    assign dbg_state = state_q;
`endif

endmodule

// File: tb/tb_controle_ula_multiciclo.sv
// tb_controle_ula_multiciclo: directed table plus randomized program checked against an ISA-level model
module tb_controle_ula_multiciclo;

    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  pc;
    logic        instr_req, instr_ack, ctrl_ula, ula_zero;
    logic [11:0] instr;
    logic [7:0]  ula_num2, ula_num1, ula_resultado;

    int checks = 0;
    int failures = 0;

    logic [7:0] m_r [4];
    logic [7:0] m_pc;

    typedef struct {
        logic [11:0] ins;
        int          stall;
        bit          stray;
        logic [7:0]  e2;
        logic [7:0]  e1;
        bit          ec;
        logic [7:0]  pc1;
    } vec_t;

    vec_t tbl[$];

    always #5 clock = ~clock;

    // Stand-in for the downstream 8-bit ALU.
    assign ula_resultado = ctrl_ula ? ula_num2 - ula_num1 : ula_num2 + ula_num1;
    assign ula_zero      = ula_resultado == 8'd0;

    controle_ula_multiciclo dut (
        .clock        (clock),
        .resetn       (resetn),
        .pc           (pc),
        .instr_req    (instr_req),
        .instr_ack    (instr_ack),
        .instr        (instr),
        .ctrl_ula     (ctrl_ula),
        .ula_num2     (ula_num2),
        .ula_num1     (ula_num1),
        .ula_resultado(ula_resultado),
        .ula_zero     (ula_zero)
    );

    function automatic logic [11:0] mk(input int op, input int rx, input int ry, input int imm);
        logic [11:0] w;
        w = {op[1:0], rx[1:0], ry[1:0], imm[5:0]};
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_step(input logic [11:0] ins, output logic [7:0] e2, output logic [7:0] e1,
                              output bit ec, output logic [7:0] npc);
        int op, rx, ry, imm, simm, t;
        op = int'(ins[11:10]);
        rx = int'(ins[9:8]);
        ry = int'(ins[7:6]);
        imm = int'(ins[5:0]);
        simm = imm >= 32 ? imm - 64 : imm;
        t = int'(m_pc) + 1;
        e2 = m_r[rx];
        e1 = m_r[ry];
        ec = (op == 1 || op == 2);
        case (op)
            0: m_r[rx] = m_r[rx] + m_r[ry];
            1: m_r[rx] = m_r[rx] - m_r[ry];
            2: if (m_r[rx] == m_r[ry]) t = t + simm;
            default: begin
                e2 = 8'(imm);
                e1 = 8'd0;
                m_r[rx] = 8'(imm);
            end
        endcase
        m_pc = 8'(((t % 256) + 256) % 256);
        npc = m_pc;
    endtask

    task automatic exec_instr(input logic [11:0] ins, input int stall, input bit stray,
                              input logic [7:0] e2, input logic [7:0] e1, input bit ec,
                              input logic [7:0] pc0, input logic [7:0] pc1, input string tag);
        chk({tag, " fetch_pc"}, 32'(pc), 32'(pc0));
        chk({tag, " fetch_req"}, 32'(instr_req), 32'd1);
        instr_ack = 1'b0;
        repeat (stall) begin
            @(posedge clock); #1;
            chk({tag, " stall_req"}, 32'(instr_req), 32'd1);
            chk({tag, " stall_pc"}, 32'(pc), 32'(pc0));
        end
        instr_ack = 1'b1;
        instr = ins;
        @(posedge clock); #1;
        instr_ack = stray;
        instr = ~ins;
        chk({tag, " decode_req"}, 32'(instr_req), 32'd0);
        @(posedge clock); #1;
        chk({tag, " exec_ops"}, 32'({ec, e2, e1}), 32'({ctrl_ula, ula_num2, ula_num1}) ^ 32'({ctrl_ula, ula_num2, ula_num1}) ^ 32'({ctrl_ula, ula_num2, ula_num1}));
        @(posedge clock); #1;
        chk({tag, " wb_ops"}, 32'({ctrl_ula, ula_num2, ula_num1}), 32'({ec, e2, e1}));
        chk({tag, " wb_req"}, 32'(instr_req), 32'd0);
        @(posedge clock); #1;
        instr_ack = 1'b0;
        chk({tag, " next_req"}, 32'(instr_req), 32'd1);
        chk({tag, " next_pc"}, 32'(pc), 32'(pc1));
    endtask

    task automatic run_model(input logic [11:0] ins, input int stall, input bit stray, input string tag);
        logic [7:0] e2, e1, p0, p1;
        bit ec;
        p0 = m_pc;
        model_step(ins, e2, e1, ec, p1);
        exec_instr(ins, stall, stray, e2, e1, ec, p0, p1, tag);
    endtask

    task automatic reset_model();
        for (int i = 0; i < 4; i++) m_r[i] = 8'd0;
        m_pc = 8'd0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d2, d1, dp, cur;
        bit dc;
        instr_ack = 1'b0;
        instr = 12'h000;
        reset_model();

        tbl.push_back('{mk(3,1,0,5),    0, 0, 8'h05, 8'h00, 0, 8'd1});
        tbl.push_back('{mk(3,2,0,3),    0, 0, 8'h03, 8'h00, 0, 8'd2});
        tbl.push_back('{mk(1,1,2,0),    0, 0, 8'h05, 8'h03, 1, 8'd3});
        tbl.push_back('{mk(2,1,1,0),    0, 0, 8'h02, 8'h02, 1, 8'd4});
        tbl.push_back('{mk(3,1,0,5),    0, 0, 8'h05, 8'h00, 0, 8'd5});
        tbl.push_back('{mk(1,2,1,0),    0, 0, 8'h03, 8'h05, 1, 8'd6});
        tbl.push_back('{mk(2,2,2,0),    0, 0, 8'hFE, 8'hFE, 1, 8'd7});
        tbl.push_back('{mk(3,1,0,7),    0, 0, 8'h07, 8'h00, 0, 8'd8});
        tbl.push_back('{mk(3,2,0,7),    0, 0, 8'h07, 8'h00, 0, 8'd9});
        tbl.push_back('{mk(2,0,0,0),    0, 0, 8'h00, 8'h00, 1, 8'd10});
        tbl.push_back('{mk(2,1,2,4),    0, 0, 8'h07, 8'h07, 1, 8'd15});
        tbl.push_back('{mk(3,2,3,8),    0, 0, 8'h08, 8'h00, 0, 8'd16});
        tbl.push_back('{mk(2,1,2,4),    0, 0, 8'h07, 8'h08, 1, 8'd17});
        tbl.push_back('{mk(2,0,0,2),    0, 0, 8'h00, 8'h00, 1, 8'd20});
        tbl.push_back('{mk(2,1,1,'h3F), 0, 0, 8'h07, 8'h07, 1, 8'd20});
        tbl.push_back('{mk(3,0,0,0),    0, 0, 8'h00, 8'h00, 0, 8'd21});
        tbl.push_back('{mk(3,3,0,1),    0, 0, 8'h01, 8'h00, 0, 8'd22});
        tbl.push_back('{mk(1,0,3,0),    0, 0, 8'h00, 8'h01, 1, 8'd23});
        tbl.push_back('{mk(0,0,3,0),    0, 0, 8'hFF, 8'h01, 0, 8'd24});
        tbl.push_back('{mk(2,0,0,0),    0, 0, 8'h00, 8'h00, 1, 8'd25});
        tbl.push_back('{mk(3,3,0,9),    3, 1, 8'h09, 8'h00, 0, 8'd26});
        tbl.push_back('{mk(2,0,0,'h24), 0, 0, 8'h00, 8'h00, 1, 8'd255});
        tbl.push_back('{mk(3,1,0,1),    0, 0, 8'h01, 8'h00, 0, 8'd0});
        tbl.push_back('{mk(2,1,1,0),    0, 0, 8'h01, 8'h01, 1, 8'd1});

        repeat (3) @(posedge clock);
        #1;
        chk("rst_req", 32'(instr_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_ops", 32'({ctrl_ula, ula_num2, ula_num1}), 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        #1;
        chk("release_req", 32'(instr_req), 32'd1);
        chk("release_pc", 32'(pc), 32'd0);

        cur = 8'd0;
        foreach (tbl[i]) begin
            model_step(tbl[i].ins, d2, d1, dc, dp);
            exec_instr(tbl[i].ins, tbl[i].stall, tbl[i].stray, tbl[i].e2, tbl[i].e1, tbl[i].ec,
                       cur, tbl[i].pc1, $sformatf("tbl%0d", i));
            cur = tbl[i].pc1;
        end

        // Reset asserted in EXEC of ADD R1,R2 must suppress the write-back.
        run_model(mk(3,1,0,3), 0, 0, "pre_rst_a");
        run_model(mk(3,2,0,4), 0, 0, "pre_rst_b");
        instr_ack = 1'b1;
        instr = mk(0,1,2,0);
        @(posedge clock); #1;
        instr_ack = 1'b0;
        @(posedge clock); #1;
        chk("midrst_exec_ops", 32'({ctrl_ula, ula_num2, ula_num1}), 32'({1'b0, 8'd3, 8'd4}));
        resetn = 1'b0;
        #1;
        chk("midrst_req", 32'(instr_req), 32'd0);
        chk("midrst_ops", 32'({ctrl_ula, ula_num2, ula_num1}), 32'd0);
        chk("midrst_pc", 32'(pc), 32'd0);
        reset_model();
        repeat (2) @(posedge clock);
        #1;
        resetn = 1'b1;
        #1;
        chk("midrst_release_req", 32'(instr_req), 32'd1);
        run_model(mk(2,1,2,0), 0, 0, "peek_r1r2");
        run_model(mk(2,0,3,0), 0, 0, "peek_r0r3");

        for (int n = 0; n < 150; n++) begin
            logic [11:0] w;
            w = 12'($urandom);
            run_model(w, int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)), $sformatf("rnd%0d", n));
        end
        for (int r = 0; r < 4; r++) run_model(mk(2, r, r, 0), 0, 0, $sformatf("final_r%0d", r));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/controle_ula_multiciclo.md
Name: controle_ula_multiciclo

Overview:
- Multicycle sequencer and operand stage directly upstream of the 8-bit ALU (ula_* ports). It also consumes the ALU result and zero flag.
- Fetches 12-bit instructions over a req/ack handshake and holds a 4x8 register file and an 8-bit PC.
- Drives ctrl_ula, ula_num2 and ula_num1 from registered operands, writes back ula_resultado, and resolves BEQ from ula_zero.

Parameters:
- DATA_W, 8, datapath width; must equal ALU width.
- PC_W, 8, program counter width; PC wraps modulo 2^PC_W.
- IMM_W, 6, immediate field width.

Ports:
- clock  in  1  single system clock; all state updates on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- pc  out  PC_W  instruction address; stable while instr_req=1.
- instr_req  out  1  fetch request.
- instr_ack  in  1  memory ack; instr valid in the same cycle.
- instr  in  12  instruction word.
- ctrl_ula  out  1  0=add (num2+num1), 1=sub (num2-num1).
- ula_num2  out  DATA_W  ALU first operand (minuend).
- ula_num1  out  DATA_W  ALU second operand.
- ula_resultado  in  DATA_W  ALU result (combinational).
- ula_zero  in  1  ALU zero flag; meaningful only when ctrl_ula=1.

Behaviour:
- Instruction encoding: op[11:10], rx[9:8], ry[7:6], imm[5:0].
  - 00 ADD: R[rx]=R[rx]+R[ry].
  - 01 SUB: R[rx]=R[rx]-R[ry].
  - 10 BEQ: if R[rx]==R[ry], PC=PC+1+sext(imm); else PC=PC+1.
  - 11 LDI: R[rx]=zext(imm).
- Reset (async, any state, including mid-fetch or mid-exec):
  - state=FETCH; PC=0; R0..R3=0; IR=0.
  - A, B, ALUOUT, Z = 0.
  - instr_req=0, ctrl_ula=0, ula_num2=0, ula_num1=0 immediately.
  - First cycle after resetn rises: instr_req=1 with pc=0.
- FSM states:
  - FETCH: instr_req=1. On instr_ack=1, IR<=instr and go to DECODE, with instr_req=0 in the next cycle. Otherwise stay, with pc held. No timeout.
  - DECODE: A<=R[rx]. B<=R[ry] for ADD/SUB/BEQ; B<=0 and A<=zext(imm) for LDI. Operands are registered and appear on ula_num2=A, ula_num1=B from the next cycle. ctrl_ula<=1 for SUB/BEQ, 0 for ADD/LDI. Go to EXEC.
  - EXEC: ALUOUT<=ula_resultado; Z<=ula_zero. Go to WB.
  - WB:
    - ADD/SUB/LDI: R[rx]<=ALUOUT; PC<=PC+1.
    - BEQ: no register write; PC<=Z ? PC+1+sext(imm) : PC+1.
    - Go to FETCH.
- Latency: 4 cycles per instruction with instr_ack in the first FETCH cycle; each extra cycle without ack adds 1.
- Arithmetic rules:
  - ALU add/sub wraps modulo 256; no carry or overflow is kept.
  - PC arithmetic wraps modulo 2^PC_W (PC=255 then +1 gives 0).
  - Branch offset range is -32..+31 relative to PC+1. BEQ with imm=-1 is an intentional self-loop.
- rx==ry is legal:
  - SUB gives 0.
  - BEQ is always taken.
- ctrl_ula, ula_num2 and ula_num1 change only in DECODE and hold through EXEC and WB.
- instr_ack while instr_req=0 is ignored.

Optional Feature:
- Macro: CONTROLE_DEBUG_PORT_EN.
- Defined: adds ports dbg_sel (in, 2) and dbg_data (out, DATA_W); dbg_data=R[dbg_sel], combinational. Also adds dbg_state (out, 2): FETCH=0, DECODE=1, EXEC=2, WB=3.
- Not defined: these ports and their logic are absent. Core behaviour is identical either way.

Decomposition:
- Shared package:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_BEQ=2'b10, OP_LDI=2'b11;
  - state encoding constants;
  - CTRL_SOMA=1'b0, CTRL_SUB=1'b1;
  - field bit positions for op/rx/ry/imm.
- One sub-module: banco_registradores (4xDATA_W; two async read ports, one sync write port, async active-low clear). The FSM, PC and operand registers stay in the top module.

Test Plan:
- Reset then LDI R1,5 with immediate ack -> ula_num2=5, ula_num1=0, ctrl_ula=0 in EXEC; R1=5 after WB; pc=1; 4 cycles total.
- R1=5, R2=3, SUB R1,R2 -> ctrl_ula=1, ALU result 2, R1=2. Then SUB R2,R1 from R2=3, R1=5 -> R2=0xFE (wrap), zero=0.
- R1=R2=7, BEQ R1,R2,imm=+4 at pc=10 -> pc=15. With R2=8 -> pc=11. BEQ imm=-1 at pc=20 with equal operands -> pc stays 20.
- Fetch stall: hold instr_ack=0 for 3 cycles -> instr_req=1 and pc constant throughout; instruction latches on the ack cycle; total 7 cycles. A stray ack while req=0 is ignored.
- ADD wrap: R0=0xFF, R3=1, ADD R0,R3 -> R0=0x00. PC wrap: instruction at pc=255 -> pc=0.
- Assert resetn low during EXEC of ADD R1,R2 -> R1 not written; all registers 0 and instr_req=0 immediately. After release, fetch from pc=0.
